mygo_chan_recv: RTL and testbench
=================================

# mygo_chan_recv

Receive-side channel endpoint that connects a compiled process FSM to the read port of a mygo channel FIFO. It converts the FIFO's valid/ready stream into a request/response transaction: blocking receive (Go `v, ok := <-ch`) or non-blocking try (`select` with `default`). It also reports Go close semantics, so a drained and closed channel returns `ok=0` with zero data. One instance sits between each FIFO `out_*` port and the process that reads that channel.

## Interface
- `WIDTH`, default 32, payload width in bits; must match the FIFO.
- `CNT_BITS`, default 16, width of the statistics counters.

- `clk`, input, 1, clock.
- `rst`, input, 1, reset, synchronous, active-high.
- `in_data`, input, WIDTH, FIFO head data (FIFO `out_data`).
- `in_valid`, input, 1, FIFO non-empty (FIFO `out_valid`).
- `in_ready`, output, 1, pop strobe to the FIFO (FIFO `out_ready`).
- `closed`, input, 1, channel closed by the sender; level, sticky upstream.
- `req`, input, 1, process requests one receive.
- `nb`, input, 1, non-blocking qualifier for `req`; sampled with `req`.
- `busy`, output, 1, a transaction is in progress (state WAIT).
- `resp_valid`, output, 1, single-cycle response pulse.
- `resp_data`, output, WIDTH, received value; 0 when `resp_ok=0`.
- `resp_ok`, output, 1, 1 = value received; 0 = closed or would-block.
- `resp_empty`, output, 1, 1 = non-blocking try found no data and the channel is not closed.
- `recv_count`, output, CNT_BITS, saturating count of pops.
- `stall_cycles`, output, CNT_BITS, saturating count of blocking wait cycles.

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- **IDLE**
  - `busy=0`, `in_ready=0`.
  - `req=1` latches `nb` and moves to WAIT.
- **WAIT**
  - `busy=1`. `in_ready = (state==WAIT) & ~rst`, combinational.
  - Resolution priority, evaluated each cycle:
    1. `in_valid=1`: pop occurs this cycle. Capture `resp_data=in_data`, `resp_ok=1`, `resp_empty=0`; go to DONE.
    2. `closed=1`: `resp_data=0`, `resp_ok=0`, `resp_empty=0`; go to DONE.
    3. latched `nb=1`: `resp_data=0`, `resp_ok=0`, `resp_empty=1`; go to DONE.
    4. Otherwise stay in WAIT, and `stall_cycles` increments.
  - Data takes priority over `closed`, so a closed channel is drained before it reports `ok=0`.
- **DONE**
  - `resp_valid=1` for exactly this cycle.
  - `req=1` in DONE latches `nb` and goes directly to WAIT (back-to-back). Otherwise go to IDLE.
- `req` in WAIT is ignored; the process must not issue one.
- `resp_data`, `resp_ok` and `resp_empty` are registered and hold their values until the next resolution.
- Counters:
  - `recv_count` increments on each pop.
  - `stall_cycles` increments in each unresolved WAIT cycle.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous): state=IDLE. `busy`, `in_ready`, `resp_valid`, `resp_data`, `resp_ok`, `resp_empty`, `recv_count`, `stall_cycles` all 0.
- Reset mid-WAIT: no pop occurs in the reset cycle (`in_ready` is gated by `rst`). No response is emitted, and the FSM returns to IDLE.

## Timing
- `req` high at cycle t (IDLE) puts the FSM in WAIT at t+1.
  - If `in_valid=1` at t+1, the pop happens at t+1 and `resp_valid` is high at t+2.
  - Minimum latency from `req` to `resp_valid` is 2 cycles.
  - Back-to-back sustained throughput is one item per 2 cycles.
- Blocking receive with an empty FIFO stays in WAIT indefinitely. If data arrives with `in_valid` rising at cycle k, the pop is at k and the response at k+1.
- A non-blocking try always resolves in its first WAIT cycle, so the response comes exactly 2 cycles after `req`.
- Pop condition: `in_valid & in_ready`, one item per pop. `in_ready` is never asserted outside WAIT.
- No combinational path from `req` to `in_ready`.

## Configuration
- Macro: `MYGO_CHAN_RECV_STATS_EN`.
- Defined: `recv_count` and `stall_cycles` are implemented as described above.
- Undefined: no counter registers are built, and both ports are tied to 0. All other behaviour is identical.

## Test plan
- **Blocking receive, FIFO holds 0xA5:** `req` at t → pop at t+1, `resp_valid` at t+2 with `resp_data=0xA5`, `resp_ok=1`, `resp_empty=0`, `recv_count=1`.
- **Blocking receive on an empty FIFO, 0x12 pushed 5 cycles later:**
  - `busy` stays high.
  - The response carries 0x12, `ok=1`.
  - `stall_cycles` equals the number of WAIT cycles before the pop.
- **Non-blocking try on an empty, open channel:** response at t+2 with `resp_ok=0`, `resp_empty=1`, `resp_data=0`, and no pop.
- **Closed channel:**
  - Setup: FIFO holds 0x01 and 0x02, `closed=1`, three back-to-back blocking receives.
  - Responses: 0x01 (ok=1), then 0x02 (ok=1), then data 0 (ok=0, empty=0).
  - Responses arrive every 2 cycles.
- **Reset during WAIT:** `rst` asserted while waiting, with `in_valid` rising in the same cycle → no pop, no `resp_valid`, all outputs 0, and the FIFO contents are unchanged.
- **Saturation, with `CNT_BITS=2` and the stats macro defined:** five receives → `recv_count` stays at 3.

Source files
------------

// File: rtl/mygo_chan_recv.sv
// Receive endpoint: turns a FIFO valid/ready read port into a blocking or non-blocking
// receive transaction with Go close semantics. Optional statistics: MYGO_CHAN_RECV_STATS_EN.
module mygo_chan_recv #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                closed,
  input  logic                req,
  input  logic                nb,
  output logic                busy,
  output logic                resp_valid,
  output logic [WIDTH-1:0]    resp_data,
  output logic                resp_ok,
  output logic                resp_empty,
  output logic [CNT_BITS-1:0] recv_count,
  output logic [CNT_BITS-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic             nb_q, nb_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ok_q, ok_d;
  logic             empty_q, empty_d;

  // Gated by rst so a reset landing mid-WAIT never pops the FIFO.
  assign in_ready   = (state_q == WAIT) & ~rst;
  assign busy       = (state_q == WAIT);
  assign resp_valid = (state_q == DONE);
  assign resp_data  = data_q;
  assign resp_ok    = ok_q;
  assign resp_empty = empty_q;

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    data_d  = data_q;
    ok_d    = ok_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: if (req) begin
        nb_d    = nb;
        state_d = WAIT;
      end
      WAIT: begin
        // Data wins over closed so a closed channel drains first.
        if (in_valid) begin
          data_d  = in_data;
          ok_d    = 1'b1;
          empty_d = 1'b0;
          state_d = DONE;
        end else if (closed) begin
          data_d  = '0;
          ok_d    = 1'b0;
          empty_d = 1'b0;
          state_d = DONE;
        end else if (nb_q) begin
          data_d  = '0;
          ok_d    = 1'b0;
          empty_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (req) begin
          nb_d    = nb;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nb_q    <= 1'b0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      empty_q <= empty_d;
    end
  end

`ifdef MYGO_CHAN_RECV_STATS_EN
  logic                pop, stall;
  logic [CNT_BITS-1:0] recv_q, recv_d, stall_q, stall_d;

  assign pop   = in_valid & in_ready;
  assign stall = (state_q == WAIT) & ~in_valid & ~closed & ~nb_q;

  // Saturating: hold at all-ones instead of wrapping.
  always_comb begin
    recv_d  = recv_q;
    stall_d = stall_q;
    if (pop && (recv_q != '1))    recv_d  = recv_q + CNT_BITS'(1);
    if (stall && (stall_q != '1)) stall_d = stall_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      recv_q  <= '0;
      stall_q <= '0;
    end else begin
      recv_q  <= recv_d;
      stall_q <= stall_d;
    end
  end

  assign recv_count   = recv_q;
  assign stall_cycles = stall_q;
`else
  assign recv_count   = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mygo_chan_recv.sv
// Self-checking bench for mygo_chan_recv: the bench plays the FIFO (a queue) and
// checks every cycle against a transaction-level reference model.
module tb_mygo_chan_recv;
  localparam int W  = 8;
  localparam int CB = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          closed;
  logic          req;
  logic          nb;
  logic          busy;
  logic          resp_valid;
  logic [W-1:0]  resp_data;
  logic          resp_ok;
  logic          resp_empty;
  logic [CB-1:0] recv_count;
  logic [CB-1:0] stall_cycles;

  always #5 clk = ~clk;

  mygo_chan_recv #(.WIDTH(W), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .closed(closed), .req(req), .nb(nb), .busy(busy), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_ok(resp_ok), .resp_empty(resp_empty),
    .recv_count(recv_count), .stall_cycles(stall_cycles)
  );

  int passed = 0;
  int total  = 0;

  logic [W-1:0] fifo [$];

  // Reference model: an outstanding transaction, a response pulse, and the last result.
  logic         m_wait = 1'b0, m_pulse = 1'b0, m_nb = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_ok = 1'b0, m_empty = 1'b0;
  int           m_recv = 0, m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int exp_cnt(input int v);
`ifdef MYGO_CHAN_RECV_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // One clock cycle: drive inputs, check in_ready, advance FIFO and model, check outputs.
  task automatic tick(input logic r, input logic n);
    logic         v, rdy;
    logic [W-1:0] d;
    logic [W-1:0] dummy;
    req = r;
    nb  = n;
    in_valid = (fifo.size() > 0);
    in_data  = in_valid ? fifo[0] : '0;
    #1;
    check("in_ready", in_ready, m_wait & ~rst);
    v = in_valid; d = in_data; rdy = in_ready;
    @(posedge clk);
    #1;
    if (v && rdy) dummy = fifo.pop_front();
    if (rst) begin
      m_wait = 0; m_pulse = 0; m_nb = 0; m_data = '0; m_ok = 0; m_empty = 0;
      m_recv = 0; m_stall = 0;
    end else if (m_wait) begin
      if (v) begin
        m_data = d; m_ok = 1; m_empty = 0; m_wait = 0; m_pulse = 1;
        if (m_recv < CMAX) m_recv++;
      end else if (closed) begin
        m_data = '0; m_ok = 0; m_empty = 0; m_wait = 0; m_pulse = 1;
      end else if (m_nb) begin
        m_data = '0; m_ok = 0; m_empty = 1; m_wait = 0; m_pulse = 1;
      end else begin
        m_pulse = 0;
        if (m_stall < CMAX) m_stall++;
      end
    end else begin
      m_pulse = 0;
      if (r) begin
        m_wait = 1;
        m_nb = n;
      end
    end
    check("busy",         busy,         m_wait);
    check("resp_valid",   resp_valid,   m_pulse);
    check("resp_data",    resp_data,    m_data);
    check("resp_ok",      resp_ok,      m_ok);
    check("resp_empty",   resp_empty,   m_empty);
    check("recv_count",   recv_count,   exp_cnt(m_recv));
    check("stall_cycles", stall_cycles, exp_cnt(m_stall));
    @(negedge clk);
  endtask

  initial begin
    rst = 1; closed = 0; req = 0; nb = 0; in_valid = 0; in_data = '0;
    @(negedge clk);
    tick(0, 0);
    tick(0, 0);
    check("reset_resp_valid", resp_valid, 0);
    rst = 0;

    // Blocking receive with data ready: response two cycles after req.
    fifo.push_back(8'hA5);
    tick(1, 0);
    tick(0, 0);
    check("a5_valid", resp_valid, 1);
    check("a5_data", resp_data, 8'hA5);
    check("a5_count", recv_count, exp_cnt(1));
    tick(0, 0);

    // Blocking receive on an empty FIFO; data appears later.
    tick(1, 0);
    repeat (4) tick(0, 0);
    check("blk_busy", busy, 1);
    fifo.push_back(8'h12);
    tick(0, 0);
    check("blk_data", resp_data, 8'h12);
    check("blk_ok", resp_ok, 1);
    check("blk_stall", stall_cycles, exp_cnt(4));
    tick(0, 0);

    // Non-blocking try on an empty open channel.
    tick(1, 1);
    tick(0, 0);
    check("nb_valid", resp_valid, 1);
    check("nb_empty", resp_empty, 1);
    check("nb_ok", resp_ok, 0);
    tick(0, 0);

    // Closed channel drains before reporting ok=0; back-to-back requests.
    fifo.push_back(8'h01);
    fifo.push_back(8'h02);
    closed = 1;
    tick(1, 0);
    tick(0, 0);
    check("cl1_data", resp_data, 8'h01);
    tick(1, 0);
    tick(0, 0);
    check("cl2_data", resp_data, 8'h02);
    check("cl2_ok", resp_ok, 1);
    tick(1, 0);
    tick(0, 0);
    check("cl3_valid", resp_valid, 1);
    check("cl3_ok", resp_ok, 0);
    check("cl3_empty", resp_empty, 0);
    tick(0, 0);
    closed = 0;

    // Reset while waiting, with data arriving in the same cycle.
    tick(1, 0);
    fifo.push_back(8'h77);
    rst = 1;
    tick(0, 0);
    check("rstw_fifo", fifo.size(), 1);
    check("rstw_valid", resp_valid, 0);
    rst = 0;
    tick(0, 0);
    check("rstw_idle_fifo", fifo.size(), 1);
    tick(1, 0);
    tick(0, 0);
    check("rstw_drain", resp_data, 8'h77);

    // Random traffic; enough pops and stalls to saturate both counters.
    for (int i = 0; i < 400; i++) begin
      logic r, n;
      if (i % 60 == 0) closed = ($urandom_range(0, 3) == 0);
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0) fifo.push_back(W'($urandom));
      r = !m_wait && ($urandom_range(0, 2) != 0);
      n = r && ($urandom_range(0, 2) == 0);
      tick(r, n);
    end
    check("sat_recv", recv_count, exp_cnt(CMAX));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
